deserializer_fsm: RTL and testbench

DESERIALIZER_FSM -- requirements
Module: deserializer_fsm

---
 rtl/fir_pkg.sv | 14 +
 rtl/deserializer_fsm_idle_timer.sv | 36 +++
 rtl/deserializer_fsm.sv | 135 +++++++++++++
 tb/tb_deserializer_fsm.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: state encoding and
// default word/timeout sizes.
package fir_pkg;

    localparam int LENGTH_DEF  = 24;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_HOLD  = 2'b10
    } state_e;

endpackage

// File: rtl/deserializer_fsm_idle_timer.sv
// Saturating idle-cycle counter; o_tc flags that one more idle cycle reaches TIMEOUT.
module idle_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TC_C = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_r;

    // Count enabled, uncleared cycles; hold at the terminal value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                cnt_r <= '0;
            end else if (cnt_r != TC_C) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_tc = (cnt_r == TC_C);

endmodule

// File: rtl/deserializer_fsm.sv
// LSB-first serial-to-parallel converter with valid/ready output handshake and
// mid-word idle timeout.
module deserializer_fsm
    import fir_pkg::*;
#(
    parameter int LENGTH  = LENGTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_din,
    input  logic              i_din_valid,
    output logic              o_ready,
    output logic [LENGTH-1:0] ov_dout,
    output logic              o_dout_valid,
    input  logic              i_ready,
    output logic              o_err
);

    localparam int CW = $clog2(LENGTH + 1);
    localparam logic [CW-1:0] LAST_C = CW'(LENGTH - 1);

    state_e            state_r, state_nxt_s;
    logic [CW-1:0]     bit_cnt_r, bit_cnt_nxt_s;
    logic [LENGTH-2:0] shift_r, shift_nxt_s;
    logic [LENGTH-1:0] shifted_s;
    logic [LENGTH-1:0] dout_r, dout_nxt_s;
    logic              valid_r, valid_nxt_s;
    logic              err_r;
    logic              ready_s, accept_s, tc_s, timeout_s, tmr_clr_s;

    // The partial word keeps only the LENGTH-1 bits gathered so far; the incoming
    // bit completes the view as the new MSB.
    assign ready_s   = i_rst_n & i_en & ((state_r == ST_IDLE) | (state_r == ST_SHIFT));
    assign accept_s  = ready_s & i_din_valid;
    assign shifted_s = {i_din, shift_r};
    assign timeout_s = i_en & (state_r == ST_SHIFT) & ~accept_s & tc_s;
    assign tmr_clr_s = (state_r != ST_SHIFT) | accept_s | timeout_s;

    idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_clr   (tmr_clr_s),
        .o_tc    (tc_s)
    );

    // Next-state and datapath update for one enabled cycle.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        dout_nxt_s    = dout_r;
        valid_nxt_s   = valid_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    shift_nxt_s   = shifted_s[LENGTH-1:1];
                    bit_cnt_nxt_s = CW'(1);
                    state_nxt_s   = ST_SHIFT;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (accept_s) begin
                    shift_nxt_s = shifted_s[LENGTH-1:1];
                    if (bit_cnt_r == LAST_C) begin
                        dout_nxt_s    = shifted_s;
                        valid_nxt_s   = 1'b1;
                        bit_cnt_nxt_s = '0;
                        state_nxt_s   = ST_HOLD;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + CW'(1);
                    end
                end else if (timeout_s) begin
                    shift_nxt_s   = '0;
                    bit_cnt_nxt_s = '0;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    state_nxt_s   = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (i_ready) begin
                    valid_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                shift_nxt_s   = '0;
                bit_cnt_nxt_s = '0;
                valid_nxt_s   = 1'b0;
                state_nxt_s   = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; the error pulse is not gated by i_en so it
    // always lasts exactly one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= '0;
            shift_r   <= '0;
            dout_r    <= '0;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            err_r <= timeout_s;
            if (i_en) begin
                state_r   <= state_nxt_s;
                bit_cnt_r <= bit_cnt_nxt_s;
                shift_r   <= shift_nxt_s;
                dout_r    <= dout_nxt_s;
                valid_r   <= valid_nxt_s;
            end else begin
                state_r   <= state_r;
                bit_cnt_r <= bit_cnt_r;
                shift_r   <= shift_r;
                dout_r    <= dout_r;
                valid_r   <= valid_r;
            end
        end
    end

    assign o_ready      = ready_s;
    assign ov_dout      = dout_r;
    assign o_dout_valid = valid_r;
    assign o_err        = err_r;

endmodule

// File: tb/tb_deserializer_fsm.sv
// Directed and randomised bench for deserializer_fsm against a bit-list reference model.
module tb_deserializer_fsm;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_en, i_din, i_din_valid, i_ready;
    logic        o_ready, o_dout_valid, o_err;
    logic [23:0] ov_dout;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: bits collected so far, pending output word, idle run length.
    logic [23:0] m_word, m_out;
    int          m_n, m_idle;
    logic        m_hold, m_valid, m_err;

    logic [23:0] tx [2];
    logic [23:0] rx [$];
    int          vcnt, bi;
    logic        en, dv, din, rdy, acc;

    deserializer_fsm dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_en),
        .i_din        (i_din),
        .i_din_valid  (i_din_valid),
        .o_ready      (o_ready),
        .ov_dout      (ov_dout),
        .o_dout_valid (o_dout_valid),
        .i_ready      (i_ready),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_word = '0; m_out = '0; m_n = 0; m_idle = 0;
        m_hold = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic m_edge(input logic e, input logic v, input logic d, input logic r);
        m_err = 1'b0;
        if (e) begin
            if (m_hold) begin
                if (r) begin
                    m_hold = 1'b0;
                    m_valid = 1'b0;
                end
            end else if (v) begin
                m_word[m_n] = d;
                m_n++;
                m_idle = 0;
                if (m_n == 24) begin
                    m_out = m_word; m_valid = 1'b1; m_hold = 1'b1;
                    m_n = 0; m_word = '0;
                end
            end else if (m_n > 0) begin
                m_idle++;
                if (m_idle == 64) begin
                    m_err = 1'b1; m_n = 0; m_word = '0; m_idle = 0;
                end
            end
        end
    endtask

    // One clock cycle, entered and left 1 time unit after a rising edge.
    task automatic cyc(input logic e, input logic v, input logic d, input logic r);
        i_en = e; i_din_valid = v; i_din = d; i_ready = r;
        #1;
        chk("ready", o_ready, e && !m_hold);
        @(posedge i_clk);
        m_edge(e, v, d, r);
        #1;
        chk("valid", o_dout_valid, m_valid);
        chk("err", o_err, m_err);
        if (m_valid) chk("dout", ov_dout, m_out);
    endtask

    task automatic send(input logic [23:0] w, input int lo, input int hi, input logic r);
        for (int i = lo; i < hi; i++) cyc(1'b1, 1'b1, w[i], r);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'($urandom), r);
    endtask

    initial begin
        m_reset();
        i_rst_n = 1'b0; i_en = 1'b1; i_din = 1'b0; i_din_valid = 1'b0; i_ready = 1'b0;
        #2;
        chk("rst_ready", o_ready, 1'b0);
        chk("rst_valid", o_dout_valid, 1'b0);
        chk("rst_dout", ov_dout, 24'h0);
        chk("rst_err", o_err, 1'b0);
        #6 i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Back-to-back word with downstream always ready
        send(24'hA5C3F1, 0, 24, 1'b1);
        chk("a5_word", ov_dout, 24'hA5C3F1);
        chk("a5_valid", o_dout_valid, 1'b1);
        idle(3, 1'b1);

        // Downstream stalls for 5 cycles while upstream keeps offering bits
        send(24'h000001, 0, 24, 1'b0);
        vcnt = int'(o_dout_valid);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'($urandom), 1'b0);
            vcnt += int'(o_dout_valid);
        end
        chk("stall_word", ov_dout, 24'h000001);
        cyc(1'b1, 1'b1, 1'($urandom), 1'b1);
        chk("stall_cycles", vcnt, 6);
        idle(70, 1'b0);

        // 63 idle cycles mid-word is tolerated; long HOLD never times out
        send(24'hFFFFFF, 0, 10, 1'b0);
        idle(63, 1'b0);
        send(24'hFFFFFF, 10, 24, 1'b0);
        chk("ffffff", ov_dout, 24'hFFFFFF);
        idle(70, 1'b0);
        idle(2, 1'b1);

        // 64 idle cycles mid-word aborts with a single error pulse
        send(24'h5A5A5A, 0, 10, 1'b1);
        idle(64, 1'b1);
        chk("err_pulse", o_err, 1'b1);
        idle(2, 1'b1);
        send(24'h5A5A5A, 0, 24, 1'b0);
        chk("5a_word", ov_dout, 24'h5A5A5A);
        idle(2, 1'b1);

        // Asynchronous reset in the middle of a word
        send(24'($urandom), 0, 12, 1'b1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", o_ready, 1'b0);
        chk("mid_rst_valid", o_dout_valid, 1'b0);
        chk("mid_rst_dout", ov_dout, 24'h0);
        chk("mid_rst_err", o_err, 1'b0);
        m_reset();
        @(posedge i_clk); #2;
        i_rst_n = 1'b1;
        send(24'h123456, 0, 24, 1'b0);
        chk("post_rst_word", ov_dout, 24'h123456);
        idle(2, 1'b1);

        // Loopback from a randomly paced serializer with random clock enable
        tx[0] = 24'h123456;
        tx[1] = 24'hFEDCBA;
        bi = 0;
        for (int c = 0; c < 3000 && rx.size() < 2; c++) begin
            en  = ($urandom_range(0, 3) != 0);
            dv  = (bi < 48) && ($urandom_range(0, 1) == 1);
            din = (bi < 48) ? tx[bi / 24][bi % 24] : 1'($urandom);
            rdy = 1'($urandom);
            if (o_dout_valid && rdy && en) rx.push_back(ov_dout);
            acc = en && !m_hold && dv;
            cyc(en, dv, din, rdy);
            if (acc) bi++;
        end
        chk("loop_count", rx.size(), 2);
        for (int i = 0; i < rx.size() && i < 2; i++) chk("loop_word", rx[i], tx[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
